// File: rtl/sram_bus_pkg.sv
// rtl/sram_bus_pkg.sv - shared types and constants for the SRAM bus responder
// Purpose: FSM state encoding, byte-lane indices and a lane-to-bitmask helper.
// Ports: none (package).
package sram_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam int LANE_A  = 0;
  localparam int LANE_B  = 1;
  localparam int LANE_C  = 2;
  localparam int LANE_D  = 3;
  localparam int BYTE_W  = 8;
  localparam int N_LANES = 4;

  // Expand a per-lane enable (1 = lane active) into a full-word bitmask.
  function automatic logic [N_LANES*BYTE_W-1:0] lane_mask(input logic [N_LANES-1:0] en);
    logic [N_LANES*BYTE_W-1:0] m;
    m = '0;
    m[LANE_A*BYTE_W +: BYTE_W] = {BYTE_W{en[LANE_A]}};
    m[LANE_B*BYTE_W +: BYTE_W] = {BYTE_W{en[LANE_B]}};
    m[LANE_C*BYTE_W +: BYTE_W] = {BYTE_W{en[LANE_C]}};
    m[LANE_D*BYTE_W +: BYTE_W] = {BYTE_W{en[LANE_D]}};
    return m;
  endfunction

endpackage

// File: rtl/sram_bus_mem.sv
// rtl/sram_bus_mem.sv - single-port byte-enable RAM with one-cycle registered read
// Purpose: word storage for the responder; contents survive reset.
// Ports:
//   clk    in  1           clock
//   addr   in  DEPTH_LOG2  word index (read and write share it)
//   wdata  in  DATA_W      write data
//   be     in  N_LANES     byte enables, 1 = write that lane
//   we     in  1           write strobe
//   rdata  out DATA_W      mem[addr] registered on clk
module sram_bus_mem
  import sram_bus_pkg::*;
#(
  parameter int              DEPTH_LOG2 = 10,
  parameter int              DATA_W     = 32,
  parameter logic [DATA_W-1:0] INIT_WORD = '0
) (
  input  logic                  clk,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [N_LANES-1:0]    be,
  input  logic                  we,
  output logic [DATA_W-1:0]     rdata
);

  // Power-up content only; no reset path touches the array.
  logic [DATA_W-1:0] mem [2**DEPTH_LOG2] = '{default: INIT_WORD};

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < N_LANES; i++) begin
        if (be[i]) mem[addr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/sram_bus_responder.sv
// rtl/sram_bus_responder.sv - device-side model of the 32-bit asynchronous SRAM bus
// Purpose: samples controller pins, stores byte-lane writes, returns reads after RD_LAT edges.
// Ports:
//   SYS_CLK, SYS_RST            clock, async active-high reset
//   SRAM_ADDR/DATA_I/CE_N/CE2_N/OE_N/WE_N/SW_N   controller-driven bus pins
//   SRAM_DATA_O, SRAM_DATA_OE   read data and drive enable for the top-level tristate
//   wr_count, rd_count          committed writes / started reads (wrapping)
//   err_contention              sticky: write began while driving the bus
//   err_addr_unstable           sticky: address moved during a write pulse
module sram_bus_responder
  import sram_bus_pkg::*;
#(
  parameter int                ADDR_W     = 18,
  parameter int                DATA_W     = 32,
  parameter int                DEPTH_LOG2 = 10,
  parameter int                RD_LAT     = 2,
  parameter logic [DATA_W-1:0] INIT_WORD  = '0
) (
  input  logic                SYS_CLK,
  input  logic                SYS_RST,
  input  logic [ADDR_W-1:0]   SRAM_ADDR,
  input  logic [DATA_W-1:0]   SRAM_DATA_I,
  output logic [DATA_W-1:0]   SRAM_DATA_O,
  output logic                SRAM_DATA_OE,
  input  logic                SRAM_CE_N,
  input  logic                SRAM_CE2_N,
  input  logic                SRAM_OE_N,
  input  logic                SRAM_WE_N,
  input  logic [N_LANES-1:0]  SRAM_SW_N,
  output logic [15:0]         wr_count,
  output logic [15:0]         rd_count,
  output logic                err_contention,
  output logic                err_addr_unstable
);

  // One edge is spent entering READ and one in the RAM read, hence the -2.
  localparam logic [7:0] LAT_LOAD = 8'(RD_LAT - 2);

  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_data;
  logic               r_ce_n, r_ce2_n, r_oe_n, r_we_n;
  logic [N_LANES-1:0] r_sw_n;
  logic               sel;

  state_t             state, state_nxt;
  logic [7:0]         cnt;
  logic [ADDR_W-1:0]  rd_addr, wr_addr;
  logic [DATA_W-1:0]  lane_data;
  logic [N_LANES-1:0] lane_en;
  logic [DATA_W-1:0]  mem_q;
  logic [DEPTH_LOG2-1:0] mem_addr;

  logic start_rd, restart_rd, hold_rd, start_wr, capture, commit, drop_oe, contention;

  always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
    if (SYS_RST) begin
      r_addr  <= '0;
      r_data  <= '0;
      r_ce_n  <= 1'b1;
      r_ce2_n <= 1'b1;
      r_oe_n  <= 1'b1;
      r_we_n  <= 1'b1;
      r_sw_n  <= '1;
    end else begin
      r_addr  <= SRAM_ADDR;
      r_data  <= SRAM_DATA_I;
      r_ce_n  <= SRAM_CE_N;
      r_ce2_n <= SRAM_CE2_N;
      r_oe_n  <= SRAM_OE_N;
      r_we_n  <= SRAM_WE_N;
      r_sw_n  <= SRAM_SW_N;
    end
  end

  assign sel = !r_ce_n && !r_ce2_n;

  always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
    if (SYS_RST) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (sel && !r_we_n)      state_nxt = WRITE;
        else if (sel && !r_oe_n) state_nxt = READ;
      end
      READ: begin
        if (!sel)                state_nxt = IDLE;
        else if (!r_we_n)        state_nxt = WRITE;
        else if (r_oe_n)         state_nxt = IDLE;
      end
      WRITE: begin
        if (!sel || r_we_n)      state_nxt = IDLE;
      end
      default:                   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start_rd   = (state == IDLE)  && (state_nxt == READ);
    hold_rd    = (state == READ)  && (state_nxt == READ);
    restart_rd = hold_rd && (r_addr != rd_addr);
    start_wr   = (state != WRITE) && (state_nxt == WRITE);
    capture    = (state == WRITE) && (state_nxt == WRITE);
    commit     = (state == WRITE) && (state_nxt == IDLE);
    drop_oe    = (state == READ)  && (state_nxt != READ);
    contention = (state == READ)  && (state_nxt == WRITE) && SRAM_DATA_OE;
    // The RAM port follows the live address except on the commit edge.
    mem_addr   = commit ? wr_addr[DEPTH_LOG2-1:0] : r_addr[DEPTH_LOG2-1:0];
  end

  sram_bus_mem #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_W     (DATA_W),
    .INIT_WORD  (INIT_WORD)
  ) u_mem (
    .clk   (SYS_CLK),
    .addr  (mem_addr),
    .wdata (lane_data),
    .be    (lane_en),
    .we    (commit),
    .rdata (mem_q)
  );

  always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
    if (SYS_RST) begin
      cnt               <= '0;
      rd_addr           <= '0;
      wr_addr           <= '0;
      lane_data         <= '0;
      lane_en           <= '0;
      SRAM_DATA_O       <= '0;
      SRAM_DATA_OE      <= 1'b0;
      wr_count          <= '0;
      rd_count          <= '0;
      err_contention    <= 1'b0;
      err_addr_unstable <= 1'b0;
    end else begin
      if (start_rd || restart_rd) begin
        cnt      <= LAT_LOAD;
        rd_addr  <= r_addr;
        rd_count <= rd_count + 16'd1;
      end else if (hold_rd) begin
        // Once the count expires the word is refreshed every cycle; an
        // address change always takes the restart branch first, so the
        // old word is held until the new one has its full latency.
        if (cnt != '0) begin
          cnt <= cnt - 8'd1;
        end else begin
          SRAM_DATA_O  <= mem_q;
          SRAM_DATA_OE <= 1'b1;
        end
      end
      if (drop_oe)    SRAM_DATA_OE   <= 1'b0;
      if (contention) err_contention <= 1'b1;

      if (start_wr) begin
        wr_addr   <= r_addr;
        lane_en   <= ~r_sw_n;
        lane_data <= r_data;
      end else if (capture) begin
        lane_en   <= lane_en | ~r_sw_n;
        lane_data <= (lane_data & ~lane_mask(~r_sw_n)) | (r_data & lane_mask(~r_sw_n));
        if (r_addr != wr_addr) err_addr_unstable <= 1'b1;
      end
      if (commit) wr_count <= wr_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_sram_bus_responder.sv
// tb/tb_sram_bus_responder.sv - directed table-driven bench for sram_bus_responder
// Purpose: applies write/read vectors plus hand sequences for latency, address change,
//          contention, simultaneous WE/OE edges, address instability and reset mid-write.
// Ports: none (top-level bench).
module tb_sram_bus_responder;

  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [17:0] addr = '0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic        oe;
  logic        ce_n = 1'b1, ce2_n = 1'b0, oe_n = 1'b1, we_n = 1'b1;
  logic [3:0]  sw_n = 4'hF;
  logic [15:0] wr_count, rd_count;
  logic        err_cont, err_addr;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_wr   = 0;
  int exp_rd   = 0;

  sram_bus_responder #(
    .ADDR_W(18), .DATA_W(32), .DEPTH_LOG2(10), .RD_LAT(RD_LAT), .INIT_WORD(32'h0)
  ) dut (
    .SYS_CLK(clk), .SYS_RST(rst), .SRAM_ADDR(addr), .SRAM_DATA_I(din),
    .SRAM_DATA_O(dout), .SRAM_DATA_OE(oe), .SRAM_CE_N(ce_n), .SRAM_CE2_N(ce2_n),
    .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n), .SRAM_SW_N(sw_n),
    .wr_count(wr_count), .rd_count(rd_count),
    .err_contention(err_cont), .err_addr_unstable(err_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          is_wr;
    logic [17:0] a;
    logic [31:0] d;
    logic [3:0]  sw;
  } vec_t;

  vec_t vecs[16];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [17:0] a, input logic [31:0] d, input logic [3:0] sw);
    ce_n = 1'b0; oe_n = 1'b1; we_n = 1'b0; addr = a; din = d; sw_n = sw;
    repeat (3) cyc();
    we_n = 1'b1;
    repeat (2) cyc();
    ce_n = 1'b1; sw_n = 4'hF;
    cyc();
    exp_wr++;
  endtask

  task automatic do_read(input string name, input logic [17:0] a, input logic [31:0] exp);
    ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1; addr = a;
    cyc();
    for (int k = 1; k <= RD_LAT; k++) begin
      cyc();
      if (k == RD_LAT - 1) chk({name, " oe early"}, {31'b0, oe}, 32'd0);
    end
    chk({name, " oe"}, {31'b0, oe}, 32'd1);
    chk({name, " data"}, dout, exp);
    oe_n = 1'b1; ce_n = 1'b1;
    repeat (2) cyc();
    chk({name, " oe off"}, {31'b0, oe}, 32'd0);
    exp_rd++;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 18'h00010, 32'h11223344, 4'h0};
    vecs[1]  = '{1'b0, 18'h00010, 32'h11223344, 4'h0};
    vecs[2]  = '{1'b1, 18'h00010, 32'hAABBCCDD, 4'b1010};
    vecs[3]  = '{1'b0, 18'h00010, 32'h11BB33DD, 4'h0};
    vecs[4]  = '{1'b1, 18'h00400, 32'h00000005, 4'h0};
    vecs[5]  = '{1'b0, 18'h00000, 32'h00000005, 4'h0};
    vecs[6]  = '{1'b1, 18'h00010, 32'hFFFFFFFF, 4'hF};
    vecs[7]  = '{1'b0, 18'h00010, 32'h11BB33DD, 4'h0};
    vecs[8]  = '{1'b1, 18'h3FFFF, 32'hCAFEF00D, 4'h0};
    vecs[9]  = '{1'b0, 18'h003FF, 32'hCAFEF00D, 4'h0};
    vecs[10] = '{1'b1, 18'h00012, 32'h12345678, 4'b0111};
    vecs[11] = '{1'b0, 18'h00012, 32'h12000000, 4'h0};
    vecs[12] = '{1'b1, 18'h00010, 32'h0000000A, 4'h0};
    vecs[13] = '{1'b1, 18'h00011, 32'h0000000B, 4'h0};
    vecs[14] = '{1'b0, 18'h00010, 32'h0000000A, 4'h0};
    vecs[15] = '{1'b0, 18'h00011, 32'h0000000B, 4'h0};

    rst = 1'b1;
    repeat (3) cyc();
    chk("reset oe", {31'b0, oe}, 32'd0);
    chk("reset data", dout, 32'd0);
    rst = 1'b0;
    cyc();

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].is_wr) do_write(vecs[i].a, vecs[i].d, vecs[i].sw);
      else do_read($sformatf("vec%0d", i), vecs[i].a, vecs[i].d);
    end
    chk("table wr_count", {16'b0, wr_count}, exp_wr);
    chk("table rd_count", {16'b0, rd_count}, exp_rd);
    chk("table no contention", {31'b0, err_cont}, 32'd0);
    chk("table no addr err", {31'b0, err_addr}, 32'd0);

    // Address change while OE_N stays low.
    ce_n = 1'b0; oe_n = 1'b0; addr = 18'h00010;
    repeat (1 + RD_LAT) cyc();
    chk("achg first", dout, 32'hA);
    addr = 18'h00011;
    cyc();
    chk("achg hold0", dout, 32'hA);
    for (int k = 1; k < RD_LAT; k++) begin
      cyc();
      chk("achg hold", dout, 32'hA);
      chk("achg oe held", {31'b0, oe}, 32'd1);
    end
    cyc();
    chk("achg new", dout, 32'hB);
    exp_rd += 2;
    chk("achg rd_count", {16'b0, rd_count}, exp_rd);
    oe_n = 1'b1; ce_n = 1'b1;
    repeat (2) cyc();

    // WE_N falls while driving the bus.
    ce_n = 1'b0; oe_n = 1'b0; addr = 18'h00010;
    repeat (1 + RD_LAT) cyc();
    chk("cont pre oe", {31'b0, oe}, 32'd1);
    exp_rd++;
    we_n = 1'b0; din = 32'h55667788; sw_n = 4'h0;
    cyc();
    chk("cont oe same", {31'b0, oe}, 32'd1);
    cyc();
    chk("cont oe drop", {31'b0, oe}, 32'd0);
    chk("cont flag", {31'b0, err_cont}, 32'd1);
    repeat (2) cyc();
    chk("cont oe in write", {31'b0, oe}, 32'd0);
    we_n = 1'b1; oe_n = 1'b1;
    repeat (2) cyc();
    ce_n = 1'b1; sw_n = 4'hF;
    cyc();
    exp_wr++;
    do_read("cont readback", 18'h00010, 32'h55667788);
    chk("cont sticky", {31'b0, err_cont}, 32'd1);
    chk("cont wr_count", {16'b0, wr_count}, exp_wr);

    // WE_N rises on the same edge OE_N falls.
    ce_n = 1'b0; oe_n = 1'b1; we_n = 1'b0; addr = 18'h00030; din = 32'h0BADBEEF; sw_n = 4'h0;
    repeat (3) cyc();
    we_n = 1'b1; oe_n = 1'b0;
    cyc();
    repeat (RD_LAT) cyc();
    chk("simul oe early", {31'b0, oe}, 32'd0);
    cyc();
    chk("simul oe", {31'b0, oe}, 32'd1);
    chk("simul data", dout, 32'h0BADBEEF);
    exp_wr++; exp_rd++;
    oe_n = 1'b1; ce_n = 1'b1; sw_n = 4'hF;
    repeat (2) cyc();
    chk("simul wr_count", {16'b0, wr_count}, exp_wr);
    chk("simul rd_count", {16'b0, rd_count}, exp_rd);

    // Address moves mid-pulse; commit stays at the latched address.
    ce_n = 1'b0; we_n = 1'b0; addr = 18'h00040; din = 32'h01020304; sw_n = 4'h0;
    repeat (3) cyc();
    addr = 18'h00041;
    repeat (2) cyc();
    we_n = 1'b1;
    repeat (2) cyc();
    ce_n = 1'b1; sw_n = 4'hF;
    cyc();
    exp_wr++;
    chk("addr flag", {31'b0, err_addr}, 32'd1);
    do_read("addr latched", 18'h00040, 32'h01020304);
    do_read("addr other", 18'h00041, 32'h00000000);

    // Reset while a write pulse is active.
    ce_n = 1'b0; we_n = 1'b0; addr = 18'h00010; din = 32'hDEADDEAD; sw_n = 4'h0;
    repeat (3) cyc();
    #2 rst = 1'b1;
    #1;
    chk("rst oe", {31'b0, oe}, 32'd0);
    chk("rst data", dout, 32'd0);
    chk("rst wr_count", {16'b0, wr_count}, 32'd0);
    chk("rst rd_count", {16'b0, rd_count}, 32'd0);
    chk("rst cont", {31'b0, err_cont}, 32'd0);
    chk("rst addr err", {31'b0, err_addr}, 32'd0);
    we_n = 1'b1; ce_n = 1'b1; sw_n = 4'hF;
    repeat (2) cyc();
    rst = 1'b0;
    cyc();
    exp_wr = 0; exp_rd = 0;
    do_read("rst mem kept", 18'h00010, 32'h55667788);
    chk("rst final wr_count", {16'b0, wr_count}, exp_wr);
    chk("rst final rd_count", {16'b0, rd_count}, exp_rd);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
